// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor BTB update path.
// Build option: BTB_COUNTER_EN selects 2-bit saturating hysteresis counters;
// without it each entry keeps a 1-bit last-outcome flag.
package bp_pkg;

  localparam int unsigned BTB_ENTRIES = 4;
  localparam int unsigned BTB_IDX_W   = 2;
  localparam int unsigned BTB_TAG_W   = 28;
  localparam int unsigned BTB_TGT_W   = 30;

  // One queued BTB write.
  typedef struct packed {
    logic [BTB_IDX_W-1:0] hash;
    logic [BTB_TAG_W-1:0] tag;
    logic [BTB_TGT_W-1:0] target;
    logic                 active;
  } btb_update_t;

  localparam int unsigned BTB_UPD_W = $bits(btb_update_t);

`ifdef BTB_COUNTER_EN
  typedef logic [1:0] btb_cnt_t;
  localparam btb_cnt_t CNT_ALLOC = 2'b10;
`else
  typedef logic [0:0] btb_cnt_t;
  localparam btb_cnt_t CNT_ALLOC = 1'b1;
`endif

  // Next counter value for a resolved outcome on a hitting entry.
  function automatic btb_cnt_t cnt_next(input btb_cnt_t cnt, input logic taken);
`ifdef BTB_COUNTER_EN
    if (taken) begin
      return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    end else begin
      return (cnt == 2'b00) ? cnt : cnt - 2'b01;
    end
`else
    cnt_next = taken;
`endif
  endfunction

  // Active bit carried by a counter value (its MSB).
  function automatic logic cnt_active(input btb_cnt_t cnt);
`ifdef BTB_COUNTER_EN
    return cnt[1];
`else
    return cnt[0];
`endif
  endfunction

endpackage

// File: rtl/btb_update_fifo.sv
// Small synchronous FIFO holding pending BTB writes. Pointers carry one extra
// wrap bit so full and empty are distinguishable without a counter.
module btb_update_fifo
  import bp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 push_i,
  input  logic [BTB_UPD_W-1:0] wdata_i,
  input  logic                 pop_i,
  output logic [BTB_UPD_W-1:0] rdata_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [BTB_UPD_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wr_ptr_q, wr_ptr_d;
  logic [AW:0]          rd_ptr_q, rd_ptr_d;
  logic                 push_en, pop_en;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance on push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_en) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_en)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer state; reset empties the queue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; empty_o guards every read.
  always_ff @(posedge CLK) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// Branch-resolution side of the 4-entry BTB: flags mispredictions with a
// registered redirect, tracks per-entry shadow tag/target/hysteresis state and
// drains BTB writes through btb_update_fifo.
// Build option: BTB_COUNTER_EN (2-bit hysteresis; otherwise 1-bit last outcome).
module btb_update_ctrl
  import bp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        resolve_valid,
  output logic        resolve_ready,
  input  logic [31:0] resolve_pc,
  input  logic        resolve_taken,
  input  logic [31:0] resolve_target,
  input  logic        resolve_pred_taken,
  input  logic [31:0] resolve_pred_target,
  input  logic        stall,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic        WEN,
  output logic [1:0]  hash_wsel,
  output logic [27:0] tag_n,
  output logic [29:0] target_n,
  output logic        active_n
);

  logic [BTB_ENTRIES-1:0] sh_valid_q, sh_valid_d;
  logic [BTB_TAG_W-1:0]   sh_tag_q [BTB_ENTRIES];
  logic [BTB_TAG_W-1:0]   sh_tag_d [BTB_ENTRIES];
  logic [BTB_TGT_W-1:0]   sh_tgt_q [BTB_ENTRIES];
  logic [BTB_TGT_W-1:0]   sh_tgt_d [BTB_ENTRIES];
  btb_cnt_t               cnt_q    [BTB_ENTRIES];
  btb_cnt_t               cnt_d    [BTB_ENTRIES];

  logic                 mispredict_q;
  logic [31:0]          redirect_pc_q;

  logic [BTB_IDX_W-1:0] res_hash;
  logic [BTB_TAG_W-1:0] res_tag;
  logic [BTB_TGT_W-1:0] res_tgt;
  logic                 accept, hit, mp_cond;
  btb_cnt_t             cnt_upd;
  logic                 act_old, act_new;
  logic [BTB_TGT_W-1:0] tgt_new;
  logic                 push;
  btb_update_t          push_data, head;
  logic [BTB_UPD_W-1:0] head_raw;
  logic                 fifo_full, fifo_empty;

  assign res_hash      = resolve_pc[3:2];
  assign res_tag       = resolve_pc[31:4];
  assign res_tgt       = resolve_target[31:2];
  assign resolve_ready = ~fifo_full;
  assign accept        = resolve_valid & resolve_ready;
  assign mp_cond       = (resolve_pred_taken != resolve_taken) ||
                         (resolve_taken && (resolve_pred_target != resolve_target));

  // Shadow lookup and update, plus the BTB write to enqueue.
  always_comb begin
    sh_valid_d = sh_valid_q;
    sh_tag_d   = sh_tag_q;
    sh_tgt_d   = sh_tgt_q;
    cnt_d      = cnt_q;
    push       = 1'b0;
    push_data  = '0;
    hit        = sh_valid_q[res_hash] && (sh_tag_q[res_hash] == res_tag);
    cnt_upd    = cnt_next(cnt_q[res_hash], resolve_taken);
    act_old    = cnt_active(cnt_q[res_hash]);
    act_new    = cnt_active(cnt_upd);
    tgt_new    = resolve_taken ? res_tgt : sh_tgt_q[res_hash];
    if (accept) begin
      if (!hit) begin
        // Not-taken misses leave the BTB alone.
        if (resolve_taken) begin
          sh_valid_d[res_hash] = 1'b1;
          sh_tag_d[res_hash]   = res_tag;
          sh_tgt_d[res_hash]   = res_tgt;
          cnt_d[res_hash]      = CNT_ALLOC;
          push                 = 1'b1;
          push_data            = '{hash: res_hash, tag: res_tag, target: res_tgt,
                                   active: cnt_active(CNT_ALLOC)};
        end
      end else begin
        cnt_d[res_hash]    = cnt_upd;
        sh_tgt_d[res_hash] = tgt_new;
        // Only write the BTB when what it holds would actually change.
        if ((act_new != act_old) || (tgt_new != sh_tgt_q[res_hash])) begin
          push      = 1'b1;
          push_data = '{hash: res_hash, tag: res_tag, target: tgt_new, active: act_new};
        end
      end
    end
  end

  // Shadow and counter state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sh_valid_q <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        sh_tag_q[i] <= '0;
        sh_tgt_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      sh_valid_q <= sh_valid_d;
      sh_tag_q   <= sh_tag_d;
      sh_tgt_q   <= sh_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  // Registered one-cycle mispredict pulse and its redirect address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mispredict_q  <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      mispredict_q <= accept & mp_cond;
      if (accept) begin
        redirect_pc_q <= resolve_taken ? resolve_target : resolve_pc + 32'd4;
      end
    end
  end

  assign mispredict  = mispredict_q;
  assign redirect_pc = redirect_pc_q;

  btb_update_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (WEN),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Write port straight from the FIFO head; zeroed when nothing is queued.
  always_comb begin
    head      = fifo_empty ? '0 : btb_update_t'(head_raw);
    WEN       = ~fifo_empty & ~stall;
    hash_wsel = head.hash;
    tag_n     = head.tag;
    target_n  = head.target;
    active_n  = head.active;
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed bench for btb_update_ctrl. BTB writes are logged at the falling
// edge and checked against hand-computed entries.
module tb_btb_update_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        resolve_valid = 1'b0;
  logic        resolve_ready;
  logic [31:0] resolve_pc = '0;
  logic        resolve_taken = 1'b0;
  logic [31:0] resolve_target = '0;
  logic        resolve_pred_taken = 1'b0;
  logic [31:0] resolve_pred_target = '0;
  logic        stall = 1'b0;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        WEN;
  logic [1:0]  hash_wsel;
  logic [27:0] tag_n;
  logic [29:0] target_n;
  logic        active_n;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [60:0] wr_log [$];
  int          wr_cyc [$];

  btb_update_ctrl #(
    .FIFO_DEPTH(2)
  ) dut (
    .CLK                 (CLK),
    .RST                 (RST),
    .resolve_valid       (resolve_valid),
    .resolve_ready       (resolve_ready),
    .resolve_pc          (resolve_pc),
    .resolve_taken       (resolve_taken),
    .resolve_target      (resolve_target),
    .resolve_pred_taken  (resolve_pred_taken),
    .resolve_pred_target (resolve_pred_target),
    .stall               (stall),
    .mispredict          (mispredict),
    .redirect_pc         (redirect_pc),
    .WEN                 (WEN),
    .hash_wsel           (hash_wsel),
    .tag_n               (tag_n),
    .target_n            (target_n),
    .active_n            (active_n)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc++;

  // A write is committed on the next rising edge; log it mid-cycle.
  always @(negedge CLK) begin
    if (!RST && WEN) begin
      wr_log.push_back({hash_wsel, tag_n, target_n, active_n});
      wr_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [60:0] wr(input logic [1:0] h, input logic [27:0] t,
                                     input logic [29:0] g, input logic a);
    return {h, t, g, a};
  endfunction

  // Checks the number of logged writes and, when nonzero, the latest one.
  task automatic check_wr(input string tag, input int exp_n, input logic [60:0] exp_last);
    check({tag, " wr count"}, 64'(wr_log.size()), 64'(exp_n));
    if (exp_n > 0 && wr_log.size() > 0) check({tag, " wr last"}, 64'(wr_log[$]), 64'(exp_last));
  endtask

  // Called just after a rising edge; returns one cycle after the result cycle.
  task automatic branch(input string tag, input logic [31:0] pc, input logic tk,
                        input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                        input logic exp_mp, input logic [31:0] exp_rd);
    resolve_pc          = pc;
    resolve_taken       = tk;
    resolve_target      = tgt;
    resolve_pred_taken  = ptk;
    resolve_pred_target = ptgt;
    resolve_valid       = 1'b1;
    check({tag, " ready"}, 64'(resolve_ready), 64'(1));
    @(posedge CLK); #1;
    resolve_valid = 1'b0;
    check({tag, " mispredict"}, 64'(mispredict), 64'(exp_mp));
    if (exp_mp) check({tag, " redirect"}, 64'(redirect_pc), 64'(exp_rd));
    @(posedge CLK); #1;
    check({tag, " pulse end"}, 64'(mispredict), 64'(0));
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] tgt);
    resolve_pc          = pc;
    resolve_taken       = 1'b1;
    resolve_target      = tgt;
    resolve_pred_taken  = 1'b0;
    resolve_pred_target = '0;
    resolve_valid       = 1'b1;
  endtask

  initial begin
    // Reset values.
    repeat (2) @(posedge CLK);
    #1;
    check("rst WEN", 64'(WEN), 64'(0));
    check("rst mispredict", 64'(mispredict), 64'(0));
    check("rst redirect", 64'(redirect_pc), 64'(0));
    check("rst ready", 64'(resolve_ready), 64'(1));
    RST = 1'b0;
    @(posedge CLK); #1;
    check("idle fields", 64'({hash_wsel, tag_n, target_n, active_n}), 64'(0));

    // Cold taken branch allocates.
    branch("cold", 32'h104, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    check_wr("cold", 1, wr(2'b01, 28'h10, 30'h80, 1'b1));

    // Hysteresis: NT, NT, T.
    branch("hys nt1", 32'h104, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h108);
    check_wr("hys nt1", 2, wr(2'b01, 28'h10, 30'h80, 1'b0));
    branch("hys nt2", 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h108);
    check_wr("hys nt2", 2, wr(2'b01, 28'h10, 30'h80, 1'b0));
    branch("hys t", 32'h104, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
`ifdef BTB_COUNTER_EN
    check_wr("hys t", 2, wr(2'b01, 28'h10, 30'h80, 1'b0));
`else
    check_wr("hys t", 3, wr(2'b01, 28'h10, 30'h80, 1'b1));
`endif

    // Drive to saturation, then a correct prediction must not write.
    branch("sat t1", 32'h104, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    check_wr("sat t1", 3, wr(2'b01, 28'h10, 30'h80, 1'b1));
    branch("sat t2", 32'h104, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    check_wr("sat t2", 3, wr(2'b01, 28'h10, 30'h80, 1'b1));
    branch("correct", 32'h104, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h200);
    check_wr("correct", 3, wr(2'b01, 28'h10, 30'h80, 1'b1));

    // Target change on a hit rewrites the entry.
    branch("newtgt", 32'h104, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h300);
    check_wr("newtgt", 4, wr(2'b01, 28'h10, 30'hC0, 1'b1));

    // Alias on hash 01 reallocates; an NT then drops active, proving cnt restarted at 10.
    branch("alias", 32'h204, 1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 32'h400);
    check_wr("alias", 5, wr(2'b01, 28'h20, 30'h100, 1'b1));
    branch("alias nt", 32'h204, 1'b0, 32'h0, 1'b1, 32'h400, 1'b1, 32'h208);
    check_wr("alias nt", 6, wr(2'b01, 28'h20, 30'h100, 1'b0));
    branch("old miss nt", 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h108);
    check_wr("old miss nt", 6, wr(2'b01, 28'h20, 30'h100, 1'b0));

    // Not-taken fall-through wraps at 2^32.
    branch("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 32'h0);
    check_wr("wrap", 6, wr(2'b01, 28'h20, 30'h100, 1'b0));

    // Stall: two accepts fill the queue, the third waits.
    stall = 1'b1;
    offer(32'h1000, 32'h5000);
    @(posedge CLK); #1;
    check("stall ready1", 64'(resolve_ready), 64'(1));
    check("stall WEN1", 64'(WEN), 64'(0));
    offer(32'h1008, 32'h6000);
    @(posedge CLK); #1;
    check("stall full", 64'(resolve_ready), 64'(0));
    offer(32'h100C, 32'h7000);
    repeat (2) @(posedge CLK);
    #1;
    check("stall held ready", 64'(resolve_ready), 64'(0));
    check("stall held WEN", 64'(WEN), 64'(0));
    check("stall no wr", 64'(wr_log.size()), 64'(6));
    stall = 1'b0;
    #1;
    check("release WEN", 64'(WEN), 64'(1));
    check("release ready", 64'(resolve_ready), 64'(0));
    @(posedge CLK); #1;
    check("after pop ready", 64'(resolve_ready), 64'(1));
    @(posedge CLK); #1;
    resolve_valid = 1'b0;
    @(posedge CLK); #1;
    check("stall wr count", 64'(wr_log.size()), 64'(9));
    if (wr_log.size() == 9) begin
      check("stall wr0", 64'(wr_log[6]), 64'(wr(2'b00, 28'h100, 30'h1400, 1'b1)));
      check("stall wr1", 64'(wr_log[7]), 64'(wr(2'b10, 28'h100, 30'h1800, 1'b1)));
      check("stall wr2", 64'(wr_log[8]), 64'(wr(2'b11, 28'h100, 30'h1C00, 1'b1)));
      check("stall back2back", 64'(wr_cyc[7] - wr_cyc[6]), 64'(1));
    end

    // Reset mid-operation flushes queued writes.
    stall = 1'b1;
    offer(32'h2000, 32'h8000);
    @(posedge CLK); #1;
    offer(32'h2004, 32'h9000);
    @(posedge CLK); #1;
    resolve_valid = 1'b0;
    check("pre-rst full", 64'(resolve_ready), 64'(0));
    RST = 1'b1;
    #1;
    check("midrst WEN", 64'(WEN), 64'(0));
    check("midrst ready", 64'(resolve_ready), 64'(1));
    check("midrst mispredict", 64'(mispredict), 64'(0));
    @(posedge CLK); #1;
    RST   = 1'b0;
    stall = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("post-rst no wr", 64'(wr_log.size()), 64'(9));
    check("post-rst WEN", 64'(WEN), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
